// File: rtl/lane_gearbox.sv
// lane_gearbox: parametrised narrow<->wide lane converter with valid/ready on
// both sides.
//   UNPACK=0 (pack):   RATIO narrow beats of LANE_W bits -> one WIDE_W word.
//   UNPACK=1 (unpack): one WIDE_W word -> RATIO narrow beats.
//   MSB_FIRST selects whether lane 0 sits in the top or bottom LANE_W bits.
// Ports:
//   div_8_clk  block clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   in_valid / in_ready / in_data / in_sof      input beat handshake
//   out_valid / out_ready / out_data / out_sof  output beat handshake
//   err / err_clr  sticky pack-mode realignment error and its clear
module lane_gearbox #(
  parameter int LANE_W    = 8,
  parameter int RATIO     = 4,
  parameter int UNPACK    = 0,
  parameter int MSB_FIRST = 1
) (
  input  logic                                           div_8_clk,
  input  logic                                           rst_n,
  input  logic                                           in_valid,
  output logic                                           in_ready,
  input  logic [(UNPACK ? LANE_W*RATIO : LANE_W)-1:0]    in_data,
  input  logic                                           in_sof,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic [(UNPACK ? LANE_W : LANE_W*RATIO)-1:0]    out_data,
  output logic                                           out_sof,
  output logic                                           err,
  input  logic                                           err_clr
);

  localparam int WIDE_W = LANE_W * RATIO;
  localparam int CNT_W  = $clog2(RATIO);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(RATIO - 1);

  if (UNPACK == 0) begin : g_pack
    logic [LANE_W-1:0] r_acc [RATIO-1];
    logic [CNT_W-1:0]  r_cnt;
    logic [WIDE_W-1:0] r_out;
    logic              r_out_valid;
    logic              r_err;
    logic [WIDE_W-1:0] w_full;
    logic              w_last;
    logic              w_in_hs;
    logic              w_out_hs;
    logic              w_realign;
    logic              w_complete;

    // Completed word: accumulated lanes 0..RATIO-2 plus the live final beat.
    for (genvar k = 0; k < RATIO; k++) begin : g_lane
      localparam int LO = (MSB_FIRST != 0) ? (WIDE_W - (k + 1) * LANE_W) : (k * LANE_W);
      if (k == RATIO - 1) begin : g_live
        assign w_full[LO +: LANE_W] = in_data;
      end else begin : g_acc
        assign w_full[LO +: LANE_W] = r_acc[k];
      end
    end

    assign w_last     = (r_cnt == LAST);
    assign in_ready   = !w_last || !r_out_valid || out_ready;
    assign w_in_hs    = in_valid && in_ready;
    assign w_out_hs   = r_out_valid && out_ready;
    assign w_realign  = w_in_hs && in_sof && (r_cnt != '0);
    assign w_complete = w_in_hs && w_last && !w_realign;

    always_ff @(posedge div_8_clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned k = 0; k < RATIO - 1; k++) r_acc[k] <= '0;
        r_cnt       <= '0;
        r_out       <= '0;
        r_out_valid <= 1'b0;
        r_err       <= 1'b0;
      end else begin
        if (w_in_hs) begin
          if (w_realign) begin
            // Drop the partial word; this beat restarts the word as lane 0.
            for (int unsigned k = 0; k < RATIO - 1; k++) r_acc[k] <= '0;
            r_acc[0] <= in_data;
            r_cnt    <= CNT_W'(1);
          end else if (w_last) begin
            r_out <= w_full;
            r_cnt <= '0;
          end else begin
            r_acc[r_cnt] <= in_data;
            r_cnt        <= r_cnt + CNT_W'(1);
          end
        end
        // A completing word in the same cycle as a drain keeps valid high.
        if (w_complete)    r_out_valid <= 1'b1;
        else if (w_out_hs) r_out_valid <= 1'b0;
        if (err_clr)        r_err <= 1'b0;
        else if (w_realign) r_err <= 1'b1;
      end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out;
    assign out_sof   = 1'b0;
    assign err       = r_err;
  end else begin : g_unpack
    logic [WIDE_W-1:0] r_word;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic [LANE_W-1:0] w_lanes [RATIO];
    logic              w_last;
    logic              w_in_hs;
    logic              w_out_hs;
    logic              w_unused;

    for (genvar k = 0; k < RATIO; k++) begin : g_lane
      localparam int LO = (MSB_FIRST != 0) ? (WIDE_W - (k + 1) * LANE_W) : (k * LANE_W);
      assign w_lanes[k] = r_word[LO +: LANE_W];
    end

    assign w_last   = (r_cnt == LAST);
    // Accepting on the last lane's drain gives zero-bubble back-to-back words.
    assign in_ready = !r_busy || (w_last && out_ready);
    assign w_in_hs  = in_valid && in_ready;
    assign w_out_hs = r_busy && out_ready;

    always_ff @(posedge div_8_clk or negedge rst_n) begin
      if (!rst_n) begin
        r_word <= '0;
        r_cnt  <= '0;
        r_busy <= 1'b0;
      end else begin
        if (w_out_hs) r_cnt <= w_last ? '0 : (r_cnt + CNT_W'(1));
        if (w_in_hs) begin
          r_word <= in_data;
          r_busy <= 1'b1;
        end else if (w_out_hs && w_last) begin
          r_busy <= 1'b0;
        end
      end
    end

    assign out_valid = r_busy;
    assign out_data  = w_lanes[r_cnt];
    assign out_sof   = r_busy && (r_cnt == '0);
    assign err       = 1'b0;
    assign w_unused  = ^{in_sof, err_clr};
  end

endmodule

// File: doc/lane_gearbox.md
# lane_gearbox

Parametrised width converter with valid/ready handshakes on both sides. It either packs RATIO narrow lanes into one wide word or unpacks one wide word into RATIO narrow lanes, with selectable lane order and start-of-frame alignment. It generalises the fixed 8↔32 converters in the serial datapath: one instance sits between deserializer and self-test, another between self-test and serializer. It runs in the divided clock domain.

## Interface
Parameters:
- LANE_W, 8, narrow lane width in bits (≥1)
- RATIO, 4, lanes per wide word (≥2); WIDE_W = LANE_W*RATIO
- UNPACK, 0, 0 = pack (narrow→wide), 1 = unpack (wide→narrow)
- MSB_FIRST, 1, 1 = lane 0 occupies the top LANE_W bits of the wide word; 0 = lane 0 occupies bits [LANE_W-1:0]

Ports:
- div_8_clk  in  1  block clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  UNPACK ? WIDE_W : LANE_W  input beat
- in_sof  in  1  pack mode: beat is lane 0 of a new word; ignored in unpack mode
- out_valid  out  1  output beat valid
- out_ready  in  1  output beat consumed when out_valid && out_ready
- out_data  out  UNPACK ? LANE_W : WIDE_W  output beat
- out_sof  out  1  unpack mode: beat is lane 0 of a word; tied 0 in pack mode
- err  out  1  sticky: pack mode realignment discarded a partial word
- err_clr  in  1  synchronous clear of err

## Operation
- Lane counter cnt has width clog2(RATIO). It counts 0..RATIO-1 and wraps to 0.
- Lane position: with MSB_FIRST=1, lane k maps to bits [WIDE_W-1-k*LANE_W -: LANE_W]. With MSB_FIRST=0, lane k maps to bits [k*LANE_W +: LANE_W].
- Pack mode:
  - An accumulator holds lanes 0..RATIO-2. A separate output register holds the completed word.
  - An accepted beat writes lane cnt, then cnt increments.
  - The beat at cnt=RATIO-1 loads the output register with the accumulator plus the current beat, sets out_valid, and wraps cnt to 0.
  - in_ready = (cnt != RATIO-1) || !out_valid || out_ready. Lanes of the next word may therefore accumulate while the output is stalled.
  - out_valid clears on an output handshake unless a new word completes in the same cycle; that case reloads the register and keeps out_valid at 1.
  - An accepted beat with in_sof=1 and cnt≠0 discards the partial word, sets err, and is written as lane 0 (cnt becomes 1).
  - in_sof=1 with cnt=0 is normal operation.
- Unpack mode:
  - A word register plus a busy flag. out_valid = busy.
  - out_data = lane cnt of the held word. out_sof = (cnt==0).
  - Each output handshake increments cnt. The handshake at cnt=RATIO-1 clears busy, unless a new word is accepted in the same cycle.
  - in_ready = !busy || (cnt==RATIO-1 && out_ready). This gives zero-bubble back-to-back words.
  - err is constant 0.
- err_clr has priority over a same-cycle err set.

## Timing
- Reset (rst_n low, asynchronous):
  - cnt=0, busy=0, out_valid=0, out_data=0, out_sof=0 (unpack mode: 1 only while valid and cnt=0), err=0.
  - Accumulator and word register are cleared to 0.
  - in_ready is combinational; after reset it is 1 in both modes.
- Pack latency: out_valid rises on the clock edge that accepts lane RATIO-1, so the word is visible the following cycle. Sustained throughput is 1 lane/cycle in, 1 word per RATIO cycles out.
- Unpack latency: out_valid rises the cycle after a word is accepted. Sustained throughput is 1 lane/cycle.
- Output stability: out_data and out_valid hold steady while out_valid && !out_ready.
- in_ready depends combinationally on out_ready. No other input-to-output combinational path is allowed.
- Reset asserted mid-word: the partial word is lost. The first beat after reset is lane 0.

## Test plan
- Pack, defaults, out_ready=1: beats 0x11,0x22,0x33,0x44 on consecutive cycles → out_data=0x11223344 with out_valid high for exactly 1 cycle, starting one cycle after the 0x44 beat.
- Pack, MSB_FIRST=0: same beats → 0x44332211. Then 8 further beats back-to-back → 2 words and no in_ready drop.
- Pack backpressure: out_ready=0, stream 0x01..0x08 → first word held at 0x01020304. 0x05..0x07 accepted, in_ready=0 when 0x08 is presented. Raise out_ready → 0x05060708 appears the next cycle.
- Pack realign: beats 0xAA,0xBB, then 0xC0 with in_sof=1, then 0xC1,0xC2,0xC3 → err=1, out_data=0xC0C1C2C3. Then err_clr=1 for 1 cycle → err=0.
- Unpack, defaults: words 0xA1B2C3D4,0x01020304 back-to-back, out_ready=1 → A1,B2,C3,D4,01,02,03,04 on 8 consecutive cycles, out_sof on A1 and 01. Toggling out_ready yields the same sequence with no loss or duplication.
- Reset mid-operation: in pack mode after 2 beats, pulse rst_n low for 1 cycle → out_valid=0, err=0. Next 4 beats 0x10..0x13 → 0x10111213.
